wb_port_arbiter: RTL

//   Producer side of the register-file write-back path. Merges in-order MEM-stage results and
//   out-of-order multiply/divide unit (MDU) results onto the single RF write port. Drives the

---
 rtl/wb_port_arbiter_if.sv | 37 +++
 rtl/wb_port_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: pipeline, MDU, hazard-query and write-back signals of the RF write-port arbiter.
interface wb_port_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic          pipe_RegWrite;
    logic [AW-1:0] pipe_write_addr;
    logic [DW-1:0] pipe_write_data;
    logic          mdu_valid;
    logic          mdu_ready;
    logic [AW-1:0] mdu_write_addr;
    logic [DW-1:0] mdu_write_data;
    logic [AW-1:0] query_rs_addr;
    logic [AW-1:0] query_rt_addr;
    logic          pending_rs;
    logic          pending_rt;
    logic          mem_wb_RegWrite;
    logic [AW-1:0] mem_wb_write_addr;
    logic [DW-1:0] mem_wb_write_data;
    logic [CW-1:0] fifo_count;
    modport master (
        output pipe_RegWrite, pipe_write_addr, pipe_write_data,
               mdu_valid, mdu_write_addr, mdu_write_data,
               query_rs_addr, query_rt_addr,
        input  mdu_ready, pending_rs, pending_rt,
               mem_wb_RegWrite, mem_wb_write_addr, mem_wb_write_data, fifo_count
    );
    modport slave (
        input  pipe_RegWrite, pipe_write_addr, pipe_write_data,
               mdu_valid, mdu_write_addr, mdu_write_data,
               query_rs_addr, query_rt_addr,
        output mdu_ready, pending_rs, pending_rt,
               mem_wb_RegWrite, mem_wb_write_addr, mem_wb_write_data, fifo_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges in-order pipeline writes and out-of-order MDU results onto the single RF write port.
module wb_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic              clk,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    r_wptr;
    logic [CW-1:0]    r_count;
    logic             r_wb_we;
    logic [AW-1:0]    r_wb_addr;
    logic [DW-1:0]    r_wb_data;
    logic             w_pipe_live;
    logic             w_empty;
    logic             w_ready;
    logic             w_fire;
    logic             w_pop;
    logic             w_pop_write;
    logic             w_bypass;
    logic             w_push;
    logic             w_push_valid;
    logic             w_pend_rs;
    logic             w_pend_rt;
    always_comb begin
        w_pipe_live  = bus.pipe_RegWrite && bus.pipe_write_addr != '0;
        w_empty      = r_count == '0;
        w_ready      = reset && r_count < CW'(DEPTH);
        w_fire       = bus.mdu_valid && w_ready;
        w_pop        = !w_pipe_live && !w_empty;
        w_pop_write  = w_pop && r_valid[r_rptr];
        w_bypass     = !w_pipe_live && w_empty && w_fire && bus.mdu_write_addr != '0;
        w_push       = w_fire && bus.mdu_write_addr != '0 && !w_bypass;
        // A pipe write to the same register in the same cycle is younger: enqueue the MDU result dead.
        w_push_valid = !(w_pipe_live && bus.pipe_write_addr == bus.mdu_write_addr);
        w_pend_rs    = 1'b0;
        w_pend_rt    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pend_rs = w_pend_rs || (r_valid[i] && r_addr[i] == bus.query_rs_addr);
            w_pend_rt = w_pend_rt || (r_valid[i] && r_addr[i] == bus.query_rt_addr);
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid   <= '0;
            r_rptr    <= '0;
            r_wptr    <= '0;
            r_count   <= '0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_we <= w_pipe_live || w_pop_write || w_bypass;
            if (w_pipe_live) begin
                r_wb_addr <= bus.pipe_write_addr;
                r_wb_data <= bus.pipe_write_data;
            end else if (w_pop_write) begin
                r_wb_addr <= r_addr[r_rptr];
                r_wb_data <= r_data[r_rptr];
            end else if (w_bypass) begin
                r_wb_addr <= bus.mdu_write_addr;
                r_wb_data <= bus.mdu_write_data;
            end
            for (int i = 0; i < DEPTH; i++)
                if (w_pipe_live && r_addr[i] == bus.pipe_write_addr) r_valid[i] <= 1'b0;
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + PW'(1);
            end
            if (w_push) begin
                r_valid[r_wptr] <= w_push_valid;
                r_addr[r_wptr]  <= bus.mdu_write_addr;
                r_data[r_wptr]  <= bus.mdu_write_data;
                r_wptr          <= r_wptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
    assign bus.mdu_ready         = w_ready;
    assign bus.pending_rs        = w_pend_rs && bus.query_rs_addr != '0;
    assign bus.pending_rt        = w_pend_rt && bus.query_rt_addr != '0;
    assign bus.mem_wb_RegWrite   = r_wb_we;
    assign bus.mem_wb_write_addr = r_wb_addr;
    assign bus.mem_wb_write_data = r_wb_data;
    assign bus.fifo_count        = r_count;
endmodule
